uart_rx_block: RTL and testbench
================================

Name: uart_rx_block

Overview:
- UART receiver for the serial stream coming back out of the cipher/rotate FPGA top (UART_RXD_OUT side); the counterpart to the testbench/host UART transmitter.
- Recovers 8N1 bytes with a 2-FF synchroniser, mid-bit sampling and stop-bit checking.
- Assembles accepted bytes into BLOCK_BYTES-wide blocks (default 16 bytes, one AES block) for checking by the bench or host-side logic.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 4.
- BLOCK_BYTES, 16, bytes per assembled block.

Ports:
- CLK100M  in  1  system clock.
- CPU_RESETN  in  1  synchronous, active-low reset.
- UART_RXD  in  1  asynchronous serial input, idle high.
- I_BLOCK_CLR  in  1  flush the partial block.
- O_RX_OUT  out  8  last accepted byte.
- O_RX_VLD  out  1  one-cycle pulse per accepted byte.
- O_FRAME_ERROR  out  1  one-cycle pulse when the stop bit is sampled 0.
- O_BLOCK  out  8*BLOCK_BYTES  last completed block; first received byte sits in the MSBs.
- O_BLOCK_VLD  out  1  one-cycle pulse when O_BLOCK updates.
- O_BUSY  out  1  high while a frame is in progress.

Behaviour:
- Reset (CPU_RESETN=0 at a CLK100M edge):
  - All outputs 0.
  - Synchroniser flops to 1; bit counter and cycle counter 0; byte index 0; assembly register 0.
  - State RESYNC.
  - A frame in progress is discarded.
- rxd_s is the UART_RXD value after 2 flops. All sampling uses rxd_s.
- States:
  - RESYNC: wait for rxd_s=1, then go to IDLE. O_BUSY=0.
  - IDLE: if rxd_s=0, go to START and clear the cycle counter.
  - START: at cycle count CLKS_PER_BIT/2-1 (integer divide), sample rxd_s.
    - rxd_s=0: go to DATA, clear the cycle and bit counters.
    - rxd_s=1: glitch; go to IDLE with no pulse and no error.
  - DATA: every CLKS_PER_BIT cycles, sample rxd_s and shift it in LSB first. After the 8th sample, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rxd_s.
    - rxd_s=1: on the same edge, O_RX_OUT<=byte and pulse O_RX_VLD; append the byte to the block; go to IDLE.
    - rxd_s=0: pulse O_FRAME_ERROR; O_RX_OUT holds its value; the byte is discarded; go to RESYNC (line break handling).
- O_BUSY=1 in START, DATA and STOP only.
- Latency: O_RX_VLD asserts 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (±1) after the falling edge of UART_RXD.
- Back-to-back frames: the return to IDLE at mid-stop bit allows a start bit arriving exactly 1 bit time after the previous stop bit.
- Block assembly:
  - An accepted byte at index k is written to assembly bits [8*(BLOCK_BYTES-k)-1 -: 8].
  - Byte index increments per accepted byte.
  - At index BLOCK_BYTES-1, the completed assembly (including the current byte) is copied to O_BLOCK and O_BLOCK_VLD pulses in the same cycle as O_RX_VLD. Index wraps to 0 and the assembly register clears.
  - O_BLOCK holds its value until the next completion.
- Frame errors and glitches do not advance the byte index.
- I_BLOCK_CLR:
  - Sets index to 0 and clears the assembly register; O_BLOCK is unchanged.
  - If it coincides with O_RX_VLD, clear wins: the byte still appears on O_RX_OUT and O_RX_VLD, but is not stored and no O_BLOCK_VLD is raised.
- Pulse outputs are registered and return to 0 on the next cycle.

Test Plan:
(All tests use CLKS_PER_BIT=16 and BLOCK_BYTES=16.)
1. Send 0xA5 (8N1, LSB first) -> O_RX_OUT=0xA5, O_RX_VLD high for exactly 1 cycle, 2+8+144 (±1) cycles after the start edge; O_FRAME_ERROR=0; O_BUSY drops on the same edge.
2. Send 16 back-to-back bytes 0x00..0x0F, no idle gap -> 16 O_RX_VLD pulses; O_BLOCK=0x000102030405060708090A0B0C0D0E0F; O_BLOCK_VLD coincides with the 16th O_RX_VLD.
3. Send 0x3C with stop bit 0, then hold the line low for 5 bit times, then send 0x11 -> one O_FRAME_ERROR pulse; no O_RX_VLD for 0x3C; no start is detected while low; 0x11 is received; byte index advances by 1 only.
4. Drive a 3-cycle low glitch on an idle line -> O_BUSY pulses briefly; no O_RX_VLD or O_FRAME_ERROR; state returns to IDLE.
5. Send 5 bytes, pulse I_BLOCK_CLR, then send 0x10..0x1F -> a single O_BLOCK_VLD with O_BLOCK=0x101112...1F; a second run with I_BLOCK_CLR coinciding with a byte's O_RX_VLD -> that byte is not stored.
6. Assert CPU_RESETN=0 for 3 cycles mid-data-bit of byte 4 -> all outputs 0; the remainder of the frame is ignored (RESYNC); the following 16-byte block 0xF0..0xFF is assembled correctly.

Source files
------------

// File: rtl/uart_rx_block.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_block
// Description : 8N1 UART receiver with block assembly. The serial input is
//               double-flopped, start bits are validated at mid-bit, data
//               bits are sampled at mid-bit LSB first, and the stop bit is
//               checked. Accepted bytes are packed into BLOCK_BYTES-wide
//               blocks with the first received byte in the MSBs.
// Ports       : CLK100M       - system clock
//               CPU_RESETN    - synchronous active-low reset
//               UART_RXD      - asynchronous serial input, idle high
//               I_BLOCK_CLR   - flush the partial block (wins over a store)
//               O_RX_OUT      - last accepted byte
//               O_RX_VLD      - one-cycle pulse per accepted byte
//               O_FRAME_ERROR - one-cycle pulse when the stop bit reads 0
//               O_BLOCK       - last completed block
//               O_BLOCK_VLD   - one-cycle pulse when O_BLOCK updates
//               O_BUSY        - high while a frame is in progress
// Parameters  : CLKS_PER_BIT >= 4, BLOCK_BYTES >= 2
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_block #(
    parameter int CLKS_PER_BIT = 868,
    parameter int BLOCK_BYTES  = 16
) (
    input  logic                     CLK100M,
    input  logic                     CPU_RESETN,
    input  logic                     UART_RXD,
    input  logic                     I_BLOCK_CLR,
    output logic [7:0]               O_RX_OUT,
    output logic                     O_RX_VLD,
    output logic                     O_FRAME_ERROR,
    output logic [8*BLOCK_BYTES-1:0] O_BLOCK,
    output logic                     O_BLOCK_VLD,
    output logic                     O_BUSY
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_BLK_W = 8 * BLOCK_BYTES;
    localparam int c_IDX_W = $clog2(BLOCK_BYTES);

    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(BLOCK_BYTES - 1);

    typedef enum logic [2:0] {
        ST_RESYNC = 3'd0,
        ST_IDLE   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_rxd_meta;
    logic                 r_rxd_s;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2:0]           r_bit;
    logic [7:0]           r_shift;
    logic [c_IDX_W-1:0]   r_byte_idx;
    logic [c_BLK_W-1:0]   r_asm;
    logic [7:0]           r_rx_out;
    logic                 r_rx_vld;
    logic                 r_frame_err;
    logic [c_BLK_W-1:0]   r_block;
    logic                 r_block_vld;

    logic                 w_cnt_clr;
    logic                 w_bit_clr;
    logic                 w_shift_en;
    logic                 w_accept;
    logic                 w_ferr;
    logic                 w_busy;
    logic [c_BLK_W-1:0]   w_ins;

    // Two-flop synchroniser; both flops reset to the idle (high) level.
    always_ff @(posedge CLK100M) begin
        if (!CPU_RESETN) begin
            r_rxd_meta <= 1'b1;
            r_rxd_s    <= 1'b1;
        end else begin
            r_rxd_meta <= UART_RXD;
            r_rxd_s    <= r_rxd_meta;
        end
    end

    always_ff @(posedge CLK100M) begin
        if (!CPU_RESETN) begin
            r_state <= ST_RESYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_bit_clr    = 1'b0;
        w_shift_en   = 1'b0;
        w_accept     = 1'b0;
        w_ferr       = 1'b0;
        case (r_state)
            ST_RESYNC: begin
                if (r_rxd_s) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!r_rxd_s) begin
                    w_state_next = ST_START;
                    w_cnt_clr    = 1'b1;
                end
            end
            ST_START: begin
                // A start bit that is no longer low at mid-bit is a glitch.
                if (r_cnt == c_CNT_HALF) begin
                    w_cnt_clr = 1'b1;
                    if (!r_rxd_s) begin
                        w_state_next = ST_DATA;
                        w_bit_clr    = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (r_cnt == c_CNT_FULL) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit == 3'd7) begin
                        w_state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                // Leaving at mid-stop lets a start bit directly follow.
                if (r_cnt == c_CNT_FULL) begin
                    w_cnt_clr = 1'b1;
                    if (r_rxd_s) begin
                        w_accept     = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_ferr       = 1'b1;
                        w_state_next = ST_RESYNC;
                    end
                end
            end
            default: begin
                w_state_next = ST_RESYNC;
            end
        endcase
    end

    assign w_busy = (r_state == ST_START) || (r_state == ST_DATA) || (r_state == ST_STOP);

    always_ff @(posedge CLK100M) begin
        if (!CPU_RESETN) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_busy) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_bit_clr) begin
                r_bit <= '0;
            end else if (w_shift_en) begin
                r_bit <= r_bit + 1'b1;
            end
            if (w_shift_en) begin
                r_shift <= {r_rxd_s, r_shift[7:1]};
            end
        end
    end

    // Current byte placed at its slot: index 0 lands in the top byte.
    assign w_ins = {r_shift, {(c_BLK_W - 8){1'b0}}} >> {r_byte_idx, 3'b000};

    always_ff @(posedge CLK100M) begin
        if (!CPU_RESETN) begin
            r_rx_out    <= '0;
            r_rx_vld    <= 1'b0;
            r_frame_err <= 1'b0;
            r_block     <= '0;
            r_block_vld <= 1'b0;
            r_byte_idx  <= '0;
            r_asm       <= '0;
        end else begin
            r_rx_vld    <= w_accept;
            r_frame_err <= w_ferr;
            r_block_vld <= 1'b0;
            if (w_accept) begin
                r_rx_out <= r_shift;
            end
            // Clear has priority: a byte accepted in the same cycle is dropped.
            if (I_BLOCK_CLR) begin
                r_byte_idx <= '0;
                r_asm      <= '0;
            end else if (w_accept) begin
                if (r_byte_idx == c_IDX_LAST) begin
                    r_block     <= r_asm | w_ins;
                    r_block_vld <= 1'b1;
                    r_byte_idx  <= '0;
                    r_asm       <= '0;
                end else begin
                    r_asm      <= r_asm | w_ins;
                    r_byte_idx <= r_byte_idx + 1'b1;
                end
            end
        end
    end

    assign O_RX_OUT      = r_rx_out;
    assign O_RX_VLD      = r_rx_vld;
    assign O_FRAME_ERROR = r_frame_err;
    assign O_BLOCK       = r_block;
    assign O_BLOCK_VLD   = r_block_vld;
    assign O_BUSY        = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_block.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_block
// Description : Directed/randomised bench for uart_rx_block with a byte-level
//               reference model of reception and block assembly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_block;

    localparam int CPB = 16;
    localparam int BB  = 16;

    logic           CLK100M;
    logic           CPU_RESETN;
    logic           UART_RXD;
    logic           I_BLOCK_CLR;
    logic [7:0]     O_RX_OUT;
    logic           O_RX_VLD;
    logic           O_FRAME_ERROR;
    logic [127:0]   O_BLOCK;
    logic           O_BLOCK_VLD;
    logic           O_BUSY;

    uart_rx_block #(
        .CLKS_PER_BIT (CPB),
        .BLOCK_BYTES  (BB)
    ) dut (
        .CLK100M       (CLK100M),
        .CPU_RESETN    (CPU_RESETN),
        .UART_RXD      (UART_RXD),
        .I_BLOCK_CLR   (I_BLOCK_CLR),
        .O_RX_OUT      (O_RX_OUT),
        .O_RX_VLD      (O_RX_VLD),
        .O_FRAME_ERROR (O_FRAME_ERROR),
        .O_BLOCK       (O_BLOCK),
        .O_BLOCK_VLD   (O_BLOCK_VLD),
        .O_BUSY        (O_BUSY)
    );

    initial begin
        CLK100M = 1'b0;
        forever #5 CLK100M = ~CLK100M;
    end

    // ---------------- observation -------------------------------------------
    int           cyc = 0;
    logic [7:0]   rx_q[$];
    logic [127:0] blk_q[$];
    int           ferr_cnt = 0;
    int           blk_novld = 0;
    int           dbl_pulse = 0;
    int           busy_cnt = 0;
    int           vld_busy_cnt = 0;
    int           last_vld_cyc = 0;
    logic         p_vld = 1'b0;
    logic         p_fe = 1'b0;
    logic         p_bv = 1'b0;

    always @(posedge CLK100M) cyc <= cyc + 1;

    always @(negedge CLK100M) begin
        if (O_RX_VLD) begin
            rx_q.push_back(O_RX_OUT);
            last_vld_cyc <= cyc;
            if (O_BUSY) vld_busy_cnt <= vld_busy_cnt + 1;
        end
        if (O_FRAME_ERROR) ferr_cnt <= ferr_cnt + 1;
        if (O_BLOCK_VLD) begin
            blk_q.push_back(O_BLOCK);
            if (!O_RX_VLD) blk_novld <= blk_novld + 1;
        end
        if ((O_RX_VLD && p_vld) || (O_FRAME_ERROR && p_fe) || (O_BLOCK_VLD && p_bv))
            dbl_pulse <= dbl_pulse + 1;
        p_vld <= O_RX_VLD;
        p_fe  <= O_FRAME_ERROR;
        p_bv  <= O_BLOCK_VLD;
        if (O_BUSY) busy_cnt <= busy_cnt + 1;
    end

    // ---------------- reference model ---------------------------------------
    int           n_vec = 0;
    int           n_err = 0;
    logic [7:0]   exp_rx[$];
    logic [127:0] exp_blk[$];
    logic [7:0]   m_asm[BB];
    int           m_idx = 0;
    int           exp_ferr = 0;
    int           lat = 0;

    function automatic logic [127:0] pack_block();
        logic [127:0] r = '0;
        for (int i = 0; i < BB; i++) r = {r[119:0], m_asm[i]};
        return r;
    endfunction

    // Byte accepted on the line; 'clr' means block clear hit the same cycle.
    task automatic model_accept(input logic [7:0] b, input bit clr);
        exp_rx.push_back(b);
        if (clr) begin
            m_idx = 0;
        end else begin
            m_asm[m_idx] = b;
            m_idx++;
            if (m_idx == BB) begin
                exp_blk.push_back(pack_block());
                m_idx = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK100M);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop);
        UART_RXD = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            UART_RXD = b[i];
            wait_cyc(CPB);
        end
        UART_RXD = stop;
        wait_cyc(CPB);
        UART_RXD = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1);
        model_accept(b, 1'b0);
    endtask

    task automatic check_all(input string tag);
        int n;
        wait_cyc(4);
        chk({tag, "_rx_count"}, 128'(rx_q.size()), 128'(exp_rx.size()));
        n = (rx_q.size() < exp_rx.size()) ? rx_q.size() : exp_rx.size();
        for (int i = 0; i < n; i++) chk({tag, "_rx_byte"}, 128'(rx_q[i]), 128'(exp_rx[i]));
        chk({tag, "_blk_count"}, 128'(blk_q.size()), 128'(exp_blk.size()));
        n = (blk_q.size() < exp_blk.size()) ? blk_q.size() : exp_blk.size();
        for (int i = 0; i < n; i++) chk({tag, "_blk_value"}, blk_q[i], exp_blk[i]);
        chk({tag, "_ferr_count"}, 128'(ferr_cnt), 128'(exp_ferr));
        chk({tag, "_blk_without_vld"}, 128'(blk_novld), 128'(0));
        chk({tag, "_long_pulse"}, 128'(dbl_pulse), 128'(0));
        chk({tag, "_busy_at_vld"}, 128'(vld_busy_cnt), 128'(0));
        rx_q.delete();
        exp_rx.delete();
        blk_q.delete();
        exp_blk.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_rx_out"}, 128'(O_RX_OUT), 128'(0));
        chk({tag, "_rx_vld"}, 128'(O_RX_VLD), 128'(0));
        chk({tag, "_frame_err"}, 128'(O_FRAME_ERROR), 128'(0));
        chk({tag, "_block"}, O_BLOCK, 128'(0));
        chk({tag, "_block_vld"}, 128'(O_BLOCK_VLD), 128'(0));
        chk({tag, "_busy"}, 128'(O_BUSY), 128'(0));
    endtask

    // ---------------- directed sequence -------------------------------------
    initial begin
        int         v0;
        int         b0;
        logic [7:0] b;

        CPU_RESETN  = 1'b0;
        UART_RXD    = 1'b1;
        I_BLOCK_CLR = 1'b0;
        wait_cyc(3);
        check_outputs_zero("reset");
        CPU_RESETN = 1'b1;
        wait_cyc(4);

        // 1: single byte, latency and pulse shape
        v0 = cyc;
        send_byte(8'hA5);
        wait_cyc(2);
        lat = last_vld_cyc - v0;
        chk("t1_latency_in_range", 128'((lat >= 153) && (lat <= 155)), 128'(1));
        chk("t1_rx_out", 128'(O_RX_OUT), 128'(8'hA5));
        check_all("t1");

        // 2: 16 back-to-back bytes from an empty block
        I_BLOCK_CLR = 1'b1;
        wait_cyc(1);
        I_BLOCK_CLR = 1'b0;
        m_idx = 0;
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        check_all("t2");
        chk("t2_block_const", O_BLOCK, 128'h000102030405060708090A0B0C0D0E0F);

        // 3: frame error, line break, then recovery; block index moves by one
        send_frame(8'h3C, 1'b0);
        exp_ferr++;
        UART_RXD = 1'b0;
        b0 = busy_cnt;
        wait_cyc(5 * CPB);
        chk("t3_no_start_while_low", 128'(busy_cnt - b0), 128'(0));
        UART_RXD = 1'b1;
        wait_cyc(CPB);
        send_byte(8'h11);
        while (m_idx != 0) send_byte(8'($urandom));
        check_all("t3");

        // 4: short low glitch on an idle line
        b0 = busy_cnt;
        UART_RXD = 1'b0;
        wait_cyc(3);
        UART_RXD = 1'b1;
        wait_cyc(2 * CPB);
        chk("t4_busy_seen", 128'((busy_cnt - b0) > 0), 128'(1));
        chk("t4_busy_now", 128'(O_BUSY), 128'(0));
        check_all("t4");

        // 5a: partial block flushed by clear
        for (int i = 0; i < 5; i++) send_byte(8'($urandom));
        I_BLOCK_CLR = 1'b1;
        wait_cyc(1);
        I_BLOCK_CLR = 1'b0;
        m_idx = 0;
        for (int i = 16; i < 32; i++) send_byte(8'(i));
        check_all("t5a");
        chk("t5a_block_const", O_BLOCK, 128'h101112131415161718191A1B1C1D1E1F);

        // 5b: clear coinciding with a byte's acceptance
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        b = 8'($urandom);
        fork
            send_frame(b, 1'b1);
            begin
                wait_cyc(lat - 1);
                I_BLOCK_CLR = 1'b1;
                wait_cyc(1);
                I_BLOCK_CLR = 1'b0;
            end
        join
        model_accept(b, 1'b1);
        for (int i = 0; i < 16; i++) send_byte(8'($urandom));
        check_all("t5b");

        // 6: reset in the middle of a data bit of the fourth byte
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        check_all("t6_pre");
        b = {6'h3F, 2'($urandom)};
        UART_RXD = 1'b0;
        wait_cyc(CPB);
        UART_RXD = b[0];
        wait_cyc(CPB);
        UART_RXD = b[1];
        wait_cyc(CPB);
        UART_RXD = 1'b1;
        wait_cyc(CPB / 2);
        CPU_RESETN = 1'b0;
        wait_cyc(1);
        check_outputs_zero("t6_in_reset");
        wait_cyc(2);
        CPU_RESETN = 1'b1;
        m_idx = 0;
        b0 = busy_cnt;
        wait_cyc(CPB / 2 + 6 * CPB);
        chk("t6_frame_ignored", 128'(busy_cnt - b0), 128'(0));
        for (int i = 240; i < 256; i++) send_byte(8'(i));
        check_all("t6");
        chk("t6_block_const", O_BLOCK, 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
